// File: rtl/painterengine_gpu_dvi_pixel_fifo_if.sv
// Pixel stream bundle between the framebuffer reader / DVI stage (master) and the pixel FIFO (slave).
interface painterengine_gpu_dvi_pixel_fifo_if;
  logic        i_wire_wr_valid;
  logic [31:0] i_wire_wr_data;
  logic        o_wire_wr_ready;
  logic        i_wire_next_rgb;
  logic [31:0] o_wire_rgba;

  modport master (
    output i_wire_wr_valid, i_wire_wr_data, i_wire_next_rgb,
    input  o_wire_wr_ready, o_wire_rgba
  );

  modport slave (
    input  i_wire_wr_valid, i_wire_wr_data, i_wire_next_rgb,
    output o_wire_wr_ready, o_wire_rgba
  );
endinterface

// File: rtl/painterengine_gpu_dvi_pixel_fifo.sv
// Show-ahead pixel FIFO feeding the DVI timing stage; the lookahead read hides the
// one-cycle lag of the DVI "consumed" pulse. Also drives a refill request and underrun stats.
module painterengine_gpu_dvi_pixel_fifo #(
  parameter int unsigned DEPTH_LOG2     = 9,
  parameter int unsigned LOW_WATERMARK  = 128,
  parameter logic [31:0] UNDERRUN_COLOR = 32'h0000_0000
) (
  input  logic                         i_wire_pixel_clock,
  input  logic                         i_wire_resetn,
  input  logic                         i_wire_frame_start,
  painterengine_gpu_dvi_pixel_fifo_if.slave pix_if,
  output logic [DEPTH_LOG2:0]          o_wire_level,
  output logic                         o_wire_empty,
  output logic                         o_wire_full,
  output logic                         o_wire_fetch_req,
  output logic                         o_wire_underrun,
  output logic [15:0]                  o_wire_underrun_count
);

  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          underrun_q, underrun_d;
  logic [15:0]   urun_cnt_q, urun_cnt_d;

  logic          push, pop, urun_evt;
  logic [PW-1:0] rd_ptr_p1;

  // Status decode straight from the level / flag registers.
  assign o_wire_level          = level_q;
  assign o_wire_empty          = (level_q == '0);
  assign o_wire_full           = (level_q == LW'(DEPTH));
  assign o_wire_fetch_req      = (level_q <= LW'(LOW_WATERMARK));
  assign o_wire_underrun       = underrun_q;
  assign o_wire_underrun_count = urun_cnt_q;
  assign pix_if.o_wire_wr_ready = !o_wire_full;

  assign push     = pix_if.i_wire_wr_valid && pix_if.o_wire_wr_ready;
  assign pop      = pix_if.i_wire_next_rgb && !o_wire_empty;
  assign urun_evt = pix_if.i_wire_next_rgb && o_wire_empty;

  // Lookahead: while the DVI stage is retiring the head, it already needs the word behind it.
  assign rd_ptr_p1 = rd_ptr_q + PW'(1);
  always_comb begin
    pix_if.o_wire_rgba = UNDERRUN_COLOR;
    if (pix_if.i_wire_next_rgb) begin
      if (level_q >= LW'(2)) pix_if.o_wire_rgba = mem_q[rd_ptr_p1];
    end else begin
      if (level_q >= LW'(1)) pix_if.o_wire_rgba = mem_q[rd_ptr_q];
    end
  end

  // Next-state: frame start flushes and drops any same-cycle push/pop/underrun.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    underrun_d = underrun_q;
    urun_cnt_d = urun_cnt_q;
    if (i_wire_frame_start) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      level_d    = '0;
      underrun_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
      if (urun_evt) begin
        underrun_d = 1'b1;
        if (urun_cnt_q != 16'hFFFF) urun_cnt_d = urun_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge i_wire_pixel_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      underrun_q <= 1'b0;
      urun_cnt_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      underrun_q <= underrun_d;
      urun_cnt_q <= urun_cnt_d;
    end
  end

  // Pixel storage is not reset; stale words are never visible because level gates the read.
  always_ff @(posedge i_wire_pixel_clock) begin
    if (push && !i_wire_frame_start) mem_q[wr_ptr_q] <= pix_if.i_wire_wr_data;
  end

endmodule

// File: tb/tb_painterengine_gpu_dvi_pixel_fifo.sv
// Bench for the DVI pixel FIFO: directed scenarios plus random traffic, all checked
// against a queue-based model of the show-ahead FIFO.
module tb_painterengine_gpu_dvi_pixel_fifo;
  localparam int unsigned DL2   = 3;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LWM   = 2;
  localparam logic [31:0] UC    = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic frame_start = 1'b0;
  logic [DL2:0] level;
  logic empty, full, fetch_req, underrun;
  logic [15:0] ucount;

  painterengine_gpu_dvi_pixel_fifo_if pix_if ();

  painterengine_gpu_dvi_pixel_fifo #(
    .DEPTH_LOG2(DL2), .LOW_WATERMARK(LWM), .UNDERRUN_COLOR(UC)
  ) dut (
    .i_wire_pixel_clock   (clk),
    .i_wire_resetn        (resetn),
    .i_wire_frame_start   (frame_start),
    .pix_if               (pix_if.slave),
    .o_wire_level         (level),
    .o_wire_empty         (empty),
    .o_wire_full          (full),
    .o_wire_fetch_req     (fetch_req),
    .o_wire_underrun      (underrun),
    .o_wire_underrun_count(ucount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model
  logic [31:0] m_q[$];
  logic        m_urun;
  int          m_cnt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model_rgba(input logic nx);
    if (nx) return (m_q.size() >= 2) ? m_q[1] : UC;
    return (m_q.size() >= 1) ? m_q[0] : UC;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".level"},    32'(level), 32'(m_q.size()));
    chk({tag, ".empty"},    32'(empty), 32'(m_q.size() == 0));
    chk({tag, ".full"},     32'(full), 32'(m_q.size() == DEPTH));
    chk({tag, ".ready"},    32'(pix_if.o_wire_wr_ready), 32'(m_q.size() != DEPTH));
    chk({tag, ".fetch"},    32'(fetch_req), 32'(m_q.size() <= LWM));
    chk({tag, ".underrun"}, 32'(underrun), 32'(m_urun));
    chk({tag, ".ucount"},   32'(ucount), 32'(m_cnt));
    chk({tag, ".rgba"},     pix_if.o_wire_rgba, model_rgba(pix_if.i_wire_next_rgb));
  endtask

  // One pixel-clock cycle: drive at negedge, check before the edge, advance model at the edge.
  task automatic step(input string tag, input logic v, input logic [31:0] d,
                      input logic nx, input logic fs, output logic [31:0] rgba_seen);
    int sz;
    @(negedge clk);
    pix_if.i_wire_wr_valid = v;
    pix_if.i_wire_wr_data  = d;
    pix_if.i_wire_next_rgb = nx;
    frame_start            = fs;
    #1;
    check_all(tag);
    rgba_seen = pix_if.o_wire_rgba;
    @(posedge clk);
    sz = m_q.size();
    if (fs) begin
      m_q.delete();
      m_urun = 1'b0;
    end else begin
      if (nx && sz == 0) begin
        m_urun = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt++;
      end
      if (nx && sz != 0) void'(m_q.pop_front());
      if (v && sz != DEPTH) m_q.push_back(d);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    pix_if.i_wire_wr_valid = 1'b0;
    pix_if.i_wire_wr_data  = '0;
    pix_if.i_wire_next_rgb = 1'b0;
    frame_start            = 1'b0;
    m_q.delete();
    m_urun = 1'b0;
    m_cnt  = 0;
    repeat (5) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset.rgba_uc", pix_if.o_wire_rgba, UC);
    chk("reset.level0", 32'(level), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  logic [31:0] r;
  logic [31:0] t2_exp [4];

  initial begin
    do_reset();

    // T2 stream
    step("t2", 1, 32'h11, 0, 0, r);
    step("t2", 1, 32'h22, 0, 0, r);
    step("t2", 1, 32'h33, 0, 0, r);
    t2_exp[0] = 32'h11; t2_exp[1] = 32'h22; t2_exp[2] = 32'h33; t2_exp[3] = UC;
    for (int i = 0; i < 4; i++) begin
      step("t2", 0, 32'h0, (i != 0), 0, r);
      chk("t2.seq", r, t2_exp[i]);
    end
    #2;
    chk("t2.level_end", 32'(level), 32'd0);
    chk("t2.no_underrun", 32'(underrun), 32'd0);

    // T3 full / wrap
    step("t3", 0, 0, 0, 1, r);
    for (int i = 0; i < 9; i++) step("t3", 1, 32'h300 + 32'(i), 0, 0, r);
    #2;
    chk("t3.full", 32'(full), 32'd1);
    chk("t3.ready", 32'(pix_if.o_wire_wr_ready), 32'd0);
    chk("t3.level8", 32'(level), 32'd8);
    for (int i = 0; i < 3; i++) step("t3", 0, 0, 1, 0, r);
    for (int i = 0; i < 3; i++) step("t3", 1, 32'h3A0 + 32'(i), 0, 0, r);
    #2;
    chk("t3.level_wrap", 32'(level), 32'd8);
    for (int i = 0; i < 9; i++) step("t3.drain", 0, 0, 1, 0, r);

    // T4 simultaneous push/pop at level 4
    step("t4", 0, 0, 0, 1, r);
    for (int i = 0; i < 4; i++) step("t4", 1, 32'h400 + 32'(i), 0, 0, r);
    step("t4", 1, 32'h4FF, 1, 0, r);
    chk("t4.lookahead", r, 32'h401);
    #2;
    chk("t4.level4", 32'(level), 32'd4);
    for (int i = 0; i < 5; i++) step("t4.drain", 0, 0, 1, 0, r);

    // T5 underrun
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step("t5", 0, 0, 1, 0, r);
      chk("t5.rgba_uc", r, UC);
    end
    #2;
    chk("t5.underrun", 32'(underrun), 32'd1);
    chk("t5.count3", 32'(ucount), 32'd3);
    chk("t5.level0", 32'(level), 32'd0);
    step("t5.fs", 0, 0, 0, 1, r);
    #2;
    chk("t5.fs_clear", 32'(underrun), 32'd0);
    chk("t5.fs_count", 32'(ucount), 32'd3);

    // T6 watermark and flush
    for (int i = 0; i < 2; i++) step("t6", 1, 32'h600 + 32'(i), 0, 0, r);
    #2;
    chk("t6.fetch_at2", 32'(fetch_req), 32'd1);
    step("t6", 1, 32'h602, 0, 0, r);
    #2;
    chk("t6.fetch_at3", 32'(fetch_req), 32'd0);
    for (int i = 0; i < 2; i++) step("t6", 1, 32'h603 + 32'(i), 0, 0, r);
    step("t6.fs_push", 1, 32'h6FF, 0, 1, r);
    #2;
    chk("t6.flush_level", 32'(level), 32'd0);
    chk("t6.flush_empty", 32'(empty), 32'd1);

    // Random traffic with one mid-run reset
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) do_reset();
      step("rand", ($urandom_range(0, 9) < 6), $urandom(), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 63) == 0), r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
